led_scan_sequencer: RTL
=======================

# led_scan_sequencer

Schedules LED calibration flashes for the LED controller inside sde_trigger. It runs a PPS-synchronous width scan: N steps, each with M flashes, and the pulse width grows by a fixed increment per step. It also arbitrates that scan against one-shot software flash requests. It drives the controller's fire strobe and pulse width, and tracks the in-flight flash from the controller's busy indication.

## Interface
Parameters:
- WIDTH_W, 8: LED pulse-width field width.
- DELAY_W, 16: PPS-to-flash delay and inter-flash gap counter width.
- COUNT_W, 8: step and flash counter width.
- BUSY_TIMEOUT, 1024: clocks allowed for an in-flight flash before error.

Ports:
- CLK120  in  1  120 MHz system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- PPS  in  1  one-PPS level, already synchronized to CLK120.
- ENABLE  in  1  scan enable level from slow control.
- START  in  1  one-cycle pulse; begins a scan.
- ABORT  in  1  one-cycle pulse; stops the scan.
- CFG_WIDTH0  in  WIDTH_W  width of the first step.
- CFG_WIDTH_STEP  in  WIDTH_W  width increment per step.
- CFG_NSTEPS  in  COUNT_W  number of steps.
- CFG_NFLASH  in  COUNT_W  flashes per step.
- CFG_DELAY  in  DELAY_W  clocks from PPS edge to the first flash of a step.
- CFG_GAP  in  DELAY_W  clocks between flashes within a step.
- SW_REQ  in  1  one-cycle software flash request.
- SW_WIDTH  in  WIDTH_W  width for the software flash.
- LED_BUSY  in  1  high while the LED controller is emitting a pulse.
- LED_FIRE  out  1  one-cycle fire strobe to the controller.
- LED_WIDTH  out  WIDTH_W  width presented with LED_FIRE; holds its value afterwards.
- LED_SRC  out  1  source of the last fire: 0 = scan, 1 = software.
- SW_ACK  out  1  one-cycle pulse, coincident with the software LED_FIRE.
- SCAN_ACTIVE  out  1  high in any state other than IDLE.
- SCAN_DONE  out  1  one-cycle pulse on normal scan completion.
- STEP_IDX  out  COUNT_W  current step, 0-based.
- ERR  out  1  sticky busy-timeout flag; cleared by an accepted START.

## Operation
- Reset: state IDLE. All outputs are 0. Counters, sw_pending, inflight and latched config are all 0.
- Config latch: an accepted START latches all CFG_* inputs. Later CFG changes do not affect the running scan.
- Scan FSM states: IDLE, ARM, DELAY, FIRE, WAIT, GAP.
  - IDLE -> ARM when START=1, ENABLE=1, CFG_NSTEPS!=0 and CFG_NFLASH!=0. This clears ERR, STEP_IDX, the flash counter, and sets width=CFG_WIDTH0. Otherwise START is ignored, and it is also ignored when not in IDLE.
  - ARM -> DELAY on a PPS rising edge (PPS=1 now, 0 in the previous cycle). Loads the delay counter with the latched delay.
  - DELAY: decrement each cycle; go to FIRE when the count is 0.
  - FIRE: assert LED_FIRE with LED_SRC=0 and LED_WIDTH=width when the grant conditions hold, then go to WAIT. Otherwise stall in FIRE.
  - WAIT -> when inflight=0, increment the flash counter.
    - If flash count < NFLASH: go to GAP, loading the gap counter.
    - Else: clear the flash counter, increment STEP_IDX, set width = min(width + step, 2^WIDTH_W - 1) (saturating add).
    - Then if STEP_IDX < NSTEPS go to ARM. Otherwise pulse SCAN_DONE and go to IDLE.
  - GAP: decrement; go to FIRE when the count is 0.
- Abort: ABORT=1, or ENABLE=0, in any non-IDLE state goes to IDLE next cycle. No SCAN_DONE. A flash already in the controller completes. sw_pending is unaffected.
- Grant conditions: a fire is allowed only when inflight=0, LED_BUSY=0, and no fire occurred in the previous cycle.
- Software priority: sw_pending is set by SW_REQ. A second SW_REQ while pending is dropped. If sw_pending and the grant conditions hold, the software flash fires: LED_FIRE, LED_SRC=1, LED_WIDTH=SW_WIDTH (sampled that cycle), SW_ACK. sw_pending clears. A scan FIRE in the same cycle stalls.
- In-flight tracking: inflight is set by any LED_FIRE. It clears on a LED_BUSY falling edge, or after BUSY_TIMEOUT clocks since the fire (that case also sets ERR). The scan proceeds normally after a timeout.

## Timing
- PPS first sampled high at cycle n, CFG_DELAY=D, no contention: LED_FIRE at cycle n+D+2.
- Within a step, with CFG_GAP=G: next LED_FIRE comes G+2 cycles after the cycle inflight clears.
- SW_REQ at cycle k, bus idle and no contention: LED_FIRE and SW_ACK at k+1.
- Reset assertion is asynchronous and takes effect immediately, mid-operation included. Deassertion is sampled on the next CLK120 edge.

## Test plan
- NSTEPS=3, NFLASH=2, WIDTH0=10, STEP=5, D=100, G=50, BUSY high 12 cycles per fire: six fires at widths 10,10,15,15,20,20. The first fire of each step is exactly 102 cycles after a PPS edge; SCAN_DONE after the 6th flash.
- WIDTH0=250, STEP=10, NSTEPS=2, NFLASH=1: widths 250, then 255 (saturated).
- SW_REQ in the same cycle the scan enters FIRE: SW fires first (LED_SRC=1, SW_ACK). The scan fire follows 2 cycles after BUSY falls, with LED_SRC=0.
- ABORT during DELAY: SCAN_ACTIVE=0 next cycle, no LED_FIRE, no SCAN_DONE. A later START restarts at STEP_IDX=0.
- LED_BUSY held low after a fire: ERR=1 at BUSY_TIMEOUT cycles and the scan continues. An accepted START clears ERR.
- START with CFG_NSTEPS=0, or with ENABLE=0: ignored, SCAN_ACTIVE stays 0.

Source files
------------

// File: rtl/led_scan_sequencer.sv
// LED calibration flash scheduler for the sde_trigger LED controller.
// Runs a PPS-synchronous pulse-width scan (N steps of M flashes, width
// growing by a fixed increment per step). One-shot software flash requests
// take priority over the scan. The block drives the controller's fire strobe
// and width, and tracks the flash in flight from the controller's busy line.
module led_scan_sequencer #(
    parameter int WIDTH_W      = 8,
    parameter int DELAY_W      = 16,
    parameter int COUNT_W      = 8,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic               CLK120,
    input  logic               RESET_N,
    input  logic               PPS,
    input  logic               ENABLE,
    input  logic               START,
    input  logic               ABORT,
    input  logic [WIDTH_W-1:0] CFG_WIDTH0,
    input  logic [WIDTH_W-1:0] CFG_WIDTH_STEP,
    input  logic [COUNT_W-1:0] CFG_NSTEPS,
    input  logic [COUNT_W-1:0] CFG_NFLASH,
    input  logic [DELAY_W-1:0] CFG_DELAY,
    input  logic [DELAY_W-1:0] CFG_GAP,
    input  logic               SW_REQ,
    input  logic [WIDTH_W-1:0] SW_WIDTH,
    input  logic               LED_BUSY,
    output logic               LED_FIRE,
    output logic [WIDTH_W-1:0] LED_WIDTH,
    output logic               LED_SRC,
    output logic               SW_ACK,
    output logic               SCAN_ACTIVE,
    output logic               SCAN_DONE,
    output logic [COUNT_W-1:0] STEP_IDX,
    output logic               ERR
);

    // Timeout counter must be able to hold BUSY_TIMEOUT itself.
    localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_FIRE  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]         state_q, state_d;
    logic               pps_prev_q, pps_prev_d;
    logic               busy_prev_q, busy_prev_d;
    logic               fire_prev_q, fire_prev_d;
    logic               sw_pending_q, sw_pending_d;
    logic               inflight_q, inflight_d;
    logic [TO_W-1:0]    timeout_cnt_q, timeout_cnt_d;
    logic               err_q, err_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] flash_cnt_q, flash_cnt_d;
    logic [COUNT_W-1:0] step_idx_q, step_idx_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [WIDTH_W-1:0] led_width_q, led_width_d;
    logic               led_src_q, led_src_d;
    logic [WIDTH_W-1:0] cfg_step_q, cfg_step_d;
    logic [COUNT_W-1:0] cfg_nsteps_q, cfg_nsteps_d;
    logic [COUNT_W-1:0] cfg_nflash_q, cfg_nflash_d;
    logic [DELAY_W-1:0] cfg_delay_q, cfg_delay_d;
    logic [DELAY_W-1:0] cfg_gap_q, cfg_gap_d;

    logic               abort_req;
    logic               start_accept;
    logic               grant;
    logic               sw_fire;
    logic               scan_fire;
    logic               led_fire;
    logic               busy_fall;
    logic               timeout_hit;
    logic               scan_done;
    logic [COUNT_W:0]   flash_next;
    logic [COUNT_W:0]   step_next;
    logic [WIDTH_W:0]   width_sum;

    // Fire arbitration: software request wins over a scan fire in the same cycle.
    always_comb begin
        abort_req    = (state_q != S_IDLE) && (ABORT || !ENABLE);
        start_accept = (state_q == S_IDLE) && START && ENABLE &&
                       (CFG_NSTEPS != '0) && (CFG_NFLASH != '0);
        grant        = !inflight_q && !LED_BUSY && !fire_prev_q;
        sw_fire      = sw_pending_q && grant;
        scan_fire    = (state_q == S_FIRE) && !abort_req && grant && !sw_pending_q;
        led_fire     = sw_fire || scan_fire;
    end

    // Presented width/source follow the winning requester and hold afterwards.
    always_comb begin
        led_width_d = led_width_q;
        led_src_d   = led_src_q;
        if (sw_fire) begin
            led_width_d = SW_WIDTH;
            led_src_d   = 1'b1;
        end else if (scan_fire) begin
            led_width_d = width_q;
            led_src_d   = 1'b0;
        end
    end

    // In-flight tracking, busy-timeout detection and the sticky error flag.
    always_comb begin
        busy_fall     = busy_prev_q && !LED_BUSY;
        timeout_hit   = inflight_q && !busy_fall &&
                        (timeout_cnt_q == TO_W'(BUSY_TIMEOUT - 1));
        inflight_d    = inflight_q;
        timeout_cnt_d = timeout_cnt_q;
        if (led_fire) begin
            inflight_d    = 1'b1;
            timeout_cnt_d = TO_W'(1);
        end else if (inflight_q) begin
            if (busy_fall || timeout_hit) begin
                inflight_d = 1'b0;
            end else begin
                timeout_cnt_d = timeout_cnt_q + TO_W'(1);
            end
        end
        err_d        = (err_q && !start_accept) || timeout_hit;
        sw_pending_d = sw_pending_q ? !sw_fire : SW_REQ;
        pps_prev_d   = PPS;
        busy_prev_d  = LED_BUSY;
        fire_prev_d  = led_fire;
    end

    // Scan sequencing: arm on PPS, count delay/gap, fire, wait for completion.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flash_cnt_d  = flash_cnt_q;
        step_idx_d   = step_idx_q;
        width_d      = width_q;
        cfg_step_d   = cfg_step_q;
        cfg_nsteps_d = cfg_nsteps_q;
        cfg_nflash_d = cfg_nflash_q;
        cfg_delay_d  = cfg_delay_q;
        cfg_gap_d    = cfg_gap_q;
        scan_done    = 1'b0;
        flash_next   = {1'b0, flash_cnt_q} + (COUNT_W + 1)'(1);
        step_next    = {1'b0, step_idx_q} + (COUNT_W + 1)'(1);
        width_sum    = {1'b0, width_q} + {1'b0, cfg_step_q};

        if (abort_req) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_accept) begin
                        state_d      = S_ARM;
                        step_idx_d   = '0;
                        flash_cnt_d  = '0;
                        width_d      = CFG_WIDTH0;
                        cfg_step_d   = CFG_WIDTH_STEP;
                        cfg_nsteps_d = CFG_NSTEPS;
                        cfg_nflash_d = CFG_NFLASH;
                        cfg_delay_d  = CFG_DELAY;
                        cfg_gap_d    = CFG_GAP;
                    end
                end
                S_ARM: begin
                    if (PPS && !pps_prev_q) begin
                        state_d = S_DELAY;
                        cnt_d   = cfg_delay_q;
                    end
                end
                S_DELAY, S_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = S_FIRE;
                    end else begin
                        cnt_d = cnt_q - DELAY_W'(1);
                    end
                end
                S_FIRE: begin
                    if (scan_fire) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!inflight_q) begin
                        if (flash_next < {1'b0, cfg_nflash_q}) begin
                            flash_cnt_d = flash_next[COUNT_W-1:0];
                            cnt_d       = cfg_gap_q;
                            state_d     = S_GAP;
                        end else begin
                            flash_cnt_d = '0;
                            step_idx_d  = step_next[COUNT_W-1:0];
                            width_d     = width_sum[WIDTH_W] ? '1 : width_sum[WIDTH_W-1:0];
                            if (step_next < {1'b0, cfg_nsteps_q}) begin
                                state_d = S_ARM;
                            end else begin
                                scan_done = 1'b1;
                                state_d   = S_IDLE;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register bank with asynchronous active-low reset.
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= S_IDLE;
            pps_prev_q    <= 1'b0;
            busy_prev_q   <= 1'b0;
            fire_prev_q   <= 1'b0;
            sw_pending_q  <= 1'b0;
            inflight_q    <= 1'b0;
            timeout_cnt_q <= '0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            flash_cnt_q   <= '0;
            step_idx_q    <= '0;
            width_q       <= '0;
            led_width_q   <= '0;
            led_src_q     <= 1'b0;
            cfg_step_q    <= '0;
            cfg_nsteps_q  <= '0;
            cfg_nflash_q  <= '0;
            cfg_delay_q   <= '0;
            cfg_gap_q     <= '0;
        end else begin
            state_q       <= state_d;
            pps_prev_q    <= pps_prev_d;
            busy_prev_q   <= busy_prev_d;
            fire_prev_q   <= fire_prev_d;
            sw_pending_q  <= sw_pending_d;
            inflight_q    <= inflight_d;
            timeout_cnt_q <= timeout_cnt_d;
            err_q         <= err_d;
            cnt_q         <= cnt_d;
            flash_cnt_q   <= flash_cnt_d;
            step_idx_q    <= step_idx_d;
            width_q       <= width_d;
            led_width_q   <= led_width_d;
            led_src_q     <= led_src_d;
            cfg_step_q    <= cfg_step_d;
            cfg_nsteps_q  <= cfg_nsteps_d;
            cfg_nflash_q  <= cfg_nflash_d;
            cfg_delay_q   <= cfg_delay_d;
            cfg_gap_q     <= cfg_gap_d;
        end
    end

    assign LED_FIRE    = led_fire;
    assign LED_WIDTH   = led_width_d;
    assign LED_SRC     = led_src_d;
    assign SW_ACK      = sw_fire;
    assign SCAN_ACTIVE = (state_q != S_IDLE);
    assign SCAN_DONE   = scan_done;
    assign STEP_IDX    = step_idx_q;
    assign ERR         = err_q;

endmodule
